// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID record: owns the PC and assembles one- and two-word
// instructions. Define FETCH_INT_EN to build interrupt handling (INT_WAIT state).
module fetch_stage #(
   parameter int unsigned     PC_W         = 32,
   parameter int unsigned     INSTR_W      = 16,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall,
   input  logic               flush,
   input  logic               pc_load,
   input  logic [PC_W-1:0]    pc_target,
   input  logic               int_req,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [INSTR_W-1:0] if_id_imm,
   output logic [PC_W-1:0]    if_id_pc,
   output logic               if_id_valid
);

`ifdef FETCH_INT_EN
   typedef enum logic [1:0] {StFetch, StImm, StIntWait} state_t;
   localparam logic [INSTR_W-1:0] INT_INSTR = INSTR_W'(16'hF000);
`else
   typedef enum logic [0:0] {StFetch, StImm} state_t;
`endif

   state_t               r_state, w_state_d;
   logic [PC_W-1:0]      r_pc, w_pc_d;
   logic [INSTR_W-1:0]   r_first, w_first_d;
   logic [INSTR_W-1:0]   r_instr, w_instr_d;
   logic [INSTR_W-1:0]   r_imm, w_imm_d;
   logic [PC_W-1:0]      r_rec_pc, w_rec_pc_d;
   logic                 r_valid, w_valid_d;
   logic                 w_bubble;
   logic                 w_in_wait;
   logic                 w_two_word;
   logic [4:0]           w_opcode;
   logic [PC_W-1:0]      w_pc_inc;

`ifdef FETCH_INT_EN
   logic                 r_int_pend, w_int_pend_d;
   assign w_in_wait = (r_state == StIntWait);
`else
   logic                 w_int_unused;
   assign w_int_unused = int_req;
   assign w_in_wait    = 1'b0;
`endif

   assign w_opcode   = imem_data[15:11];
   assign w_two_word = (w_opcode == 5'b1_0010) || (w_opcode == 5'b1_0011) ||
                       (w_opcode == 5'b1_0100);
   assign w_pc_inc   = r_pc + PC_W'(1);

   always_comb begin
      w_state_d  = r_state;
      w_pc_d     = r_pc;
      w_first_d  = r_first;
      w_instr_d  = r_instr;
      w_imm_d    = r_imm;
      w_rec_pc_d = r_rec_pc;
      w_valid_d  = r_valid;
      w_bubble   = 1'b0;
`ifdef FETCH_INT_EN
      w_int_pend_d = r_int_pend | int_req;
`endif
      if (pc_load) begin
         w_pc_d    = pc_target;
         w_state_d = StFetch;
         w_bubble  = 1'b1;
      end else if (flush) begin
         // A flushed first word is dropped, so the stage stays in (or returns to) FETCH.
         w_bubble = 1'b1;
         if (!w_in_wait) begin
            w_pc_d    = w_pc_inc;
            w_state_d = StFetch;
         end
      end else if (!stall) begin
         unique case (r_state)
            StFetch: begin
`ifdef FETCH_INT_EN
               if (r_int_pend) begin
                  w_instr_d    = INT_INSTR;
                  w_imm_d      = '0;
                  w_rec_pc_d   = r_pc;
                  w_valid_d    = 1'b1;
                  w_state_d    = StIntWait;
                  w_int_pend_d = int_req;
               end else
`endif
               if (w_two_word) begin
                  w_first_d = imem_data;
                  w_bubble  = 1'b1;
                  w_pc_d    = w_pc_inc;
                  w_state_d = StImm;
               end else begin
                  w_instr_d  = imem_data;
                  w_imm_d    = '0;
                  w_rec_pc_d = w_pc_inc;
                  w_valid_d  = 1'b1;
                  w_pc_d     = w_pc_inc;
               end
            end
            StImm: begin
               w_instr_d  = r_first;
               w_imm_d    = imem_data;
               w_rec_pc_d = w_pc_inc;
               w_valid_d  = 1'b1;
               w_pc_d     = w_pc_inc;
               w_state_d  = StFetch;
            end
`ifdef FETCH_INT_EN
            StIntWait: w_bubble = 1'b1;
`endif
            default: w_state_d = StFetch;
         endcase
      end
      if (w_bubble) begin
         w_instr_d  = '0;
         w_imm_d    = '0;
         w_rec_pc_d = '0;
         w_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= StFetch;
         r_pc     <= RESET_VECTOR;
         r_first  <= '0;
         r_instr  <= '0;
         r_imm    <= '0;
         r_rec_pc <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_pc     <= w_pc_d;
         r_first  <= w_first_d;
         r_instr  <= w_instr_d;
         r_imm    <= w_imm_d;
         r_rec_pc <= w_rec_pc_d;
         r_valid  <= w_valid_d;
      end
   end

`ifdef FETCH_INT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_int_pend <= 1'b0;
      end else begin
         r_int_pend <= w_int_pend_d;
      end
   end
`endif

   assign imem_addr   = r_pc;
   assign if_id_instr = r_instr;
   assign if_id_imm   = r_imm;
   assign if_id_pc    = r_rec_pc;
   assign if_id_valid = r_valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline buffer for the five-stage processor. It owns the PC, drives the instruction-memory address, and assembles one- and two-word instructions into a single IF/ID record. The record feeds the decode stage, whose control unit decodes `if_id_instr[15:11]`. On stall the stage holds, on flush it inserts a NOP bubble (all-zero instruction), and on redirect it reloads the PC from jump, call, return or interrupt targets.

## Interface
Parameters:
- `PC_W`, 32, PC and address width
- `INSTR_W`, 16, instruction and immediate word width
- `RESET_VECTOR`, 0, PC value loaded on reset

Ports:
- `clk`  in  1  clock, rising-edge active
- `reset`  in  1  asynchronous, active-high reset
- `imem_addr`  out  PC_W  instruction-memory address, equal to the current PC
- `imem_data`  in  INSTR_W  word at `imem_addr`, combinational read, valid in the same cycle
- `stall`  in  1  hold PC, state and IF/ID record
- `flush`  in  1  replace the next IF/ID record with a bubble
- `pc_load`  in  1  redirect the PC to `pc_target`
- `pc_target`  in  PC_W  redirect address
- `int_req`  in  1  interrupt request, level, sampled on `clk`
- `if_id_instr`  out  INSTR_W  buffered instruction; `[15:11]` is the op_code
- `if_id_imm`  out  INSTR_W  buffered immediate, 0 for one-word instructions
- `if_id_pc`  out  PC_W  address of the word after the instruction (return address)
- `if_id_valid`  out  1  record holds a real instruction

## Operation
- States: `FETCH`, `IMM`, `INT_WAIT`.
- Two-word op_codes: `5'b1_0010` (LDM), `5'b1_0011` (LDD), `5'b1_0100` (STD). All other op_codes are one-word.
- `FETCH`, one-word instruction:
  - Record becomes {`imem_data`, 0, PC+1}, valid=1.
  - PC advances to PC+1.
- `FETCH`, two-word instruction:
  - Latch `imem_data` into the internal `first_word` register.
  - Record becomes a bubble, valid=0.
  - PC advances to PC+1 and state goes to `IMM`.
- `IMM`:
  - Record becomes {`first_word`, `imem_data`, PC+1}, valid=1.
  - PC advances to PC+1 and state returns to `FETCH`.
- Priority per cycle: `reset` > `pc_load` > `flush` > `stall` > normal.
- `pc_load`:
  - PC is set to `pc_target` and state goes to `FETCH`.
  - The record becomes a bubble. A partially fetched two-word instruction is discarded.
- `flush` without `pc_load`:
  - The record becomes a bubble, and PC and state advance normally.
  - If the flush hits the first word of a two-word instruction, that word is dropped and state stays `FETCH`. PC still advances to PC+1.
- `stall` alone: PC, state, `first_word` and the record all hold.
- Bubble: instr=0, imm=0, pc=0, valid=0. Op_code `0_0000` decodes to NOP downstream.
- PC arithmetic is modulo 2^PC_W and wraps silently.

## Timing
- Reset (asynchronous) sets:
  - PC=`RESET_VECTOR`, `imem_addr`=`RESET_VECTOR`
  - state=`FETCH`, `first_word`=0
  - record=bubble, interrupt-pending=0
- Record outputs are registered and change only on the rising edge of `clk`.
- One-word latency: the record is valid one cycle after the word is presented on `imem_data`.
- Two-word latency: the record is valid one cycle after the immediate word is presented, two cycles after the first word.
- Throughput: one word per cycle when not stalled.
- When `stall` and `flush` are asserted together, `flush` wins and the bubble is written.
- `stall` asserted in `IMM` holds `first_word`. The immediate is captured on the first non-stalled cycle.

## Configuration
- Macro: `FETCH_INT_EN`.
- Defined, the stage handles interrupts:
  - `int_req` sampled high sets interrupt-pending.
  - Pending is serviced only in `FETCH` with no `stall`, `flush` or `pc_load`, so never between the two words of an instruction.
  - On service, the record becomes {`16'hF000` (op_code `5'b1_1110`), 0, current PC}, valid=1. The PC is not advanced.
  - On service, pending clears and state goes to `INT_WAIT`.
  - `INT_WAIT` emits bubbles and holds the PC until `pc_load`. `flush` does not leave `INT_WAIT`.
- Not defined:
  - `int_req` is ignored and the `INT_WAIT` state is not built.
  - All ports remain present.

## Test plan
- Reset during fetch:
  - Stimulus: `RESET_VECTOR`=0x10, assert `reset` mid-cycle.
  - Response: `imem_addr`=0x10 immediately, `if_id_valid`=0, state `FETCH`.
- One-word stream:
  - Stimulus: words 0x1800 (NOT) at 0x10, 0x4800 (ADD) at 0x11.
  - Response: records (0x1800, 0, 0x11) then (0x4800, 0, 0x12), valid=1 on consecutive cycles.
- LDM two-word:
  - Stimulus: 0x9000 at 0x20, immediate 0xBEEF at 0x21.
  - Response: one bubble, then record (0x9000, 0xBEEF, 0x22).
  - The next fetch address is 0x22.
- Stall in `IMM`:
  - Stimulus: LDM as above with `stall`=1 for 3 cycles after the first word.
  - Response: record and PC hold, then a single record (0x9000, 0xBEEF, 0x22).
- Redirect mid two-word:
  - Stimulus: `pc_load`=1 with `pc_target`=0x40 in the `IMM` cycle.
  - Response: bubble, `imem_addr`=0x40 next cycle, LDM discarded.
  - The next record comes from address 0x40.
- Interrupt (`FETCH_INT_EN` defined):
  - Stimulus: `int_req` pulse while at PC 0x30.
  - Response: record (0xF000, 0, 0x30), then bubbles with PC held until `pc_load`.
  - Without the macro, the stream continues unaffected.
